// File: rtl/dmem_hs.sv
// dmem_hs: byte-addressed little-endian data memory behind a valid/ready request/response handshake.
// Define DMEM_MISALIGN_EN to let misaligned half/word accesses complete (address wrap, one extra wait cycle).
module dmem_hs #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(WAIT_CYC + 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0] mem [DEPTH];

    logic              acc_we;
    logic [1:0]        acc_size;
    logic              acc_uns;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic              misaligned, fault, accept, do_access, mem_we;
    logic [CNT_W-1:0]  wait_total;
    logic [DATA_W-1:0] load_data;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With WAIT_CYC=0 the access happens on the accept edge, so operands come straight from the request.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        misaligned = ((acc_size == 2'b01) && acc_addr[0]) ||
                     ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_EN
        fault      = (acc_size == 2'b11);
        a1         = acc_addr + ADDR_W'(1);
        a2         = acc_addr + ADDR_W'(2);
        a3         = acc_addr + ADDR_W'(3);
        wait_total = CNT_W'(WAIT_CYC) + CNT_W'(misaligned);
`else
        // Aligned accesses never carry out of the low address bits, so OR-ing the lane offset suffices.
        fault      = (acc_size == 2'b11) || misaligned;
        a1         = acc_addr | ADDR_W'(1);
        a2         = acc_addr | ADDR_W'(2);
        a3         = acc_addr | ADDR_W'(3);
        wait_total = CNT_W'(WAIT_CYC);
`endif
        b0 = mem[acc_addr];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        case (acc_size)
            2'b00:   load_data = {{24{!acc_uns && b0[7]}}, b0};
            2'b01:   load_data = {{16{!acc_uns && b1[7]}}, b1, b0};
            default: load_data = {b3, b2, b1, b0};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (wait_total == '0) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = wait_total - CNT_W'(1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            err_d   = fault;
            rdata_d = (fault || acc_we) ? '0 : load_data;
        end
        mem_we = do_access && acc_we && !fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_addr] <= acc_wdata[7:0];
            if (acc_size != 2'b00) begin
                mem[a1] <= acc_wdata[15:8];
            end
            if (acc_size == 2'b10) begin
                mem[a2] <= acc_wdata[23:16];
                mem[a3] <= acc_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: randomized self-checking bench for dmem_hs against a byte-array reference model.
// Expectations follow DMEM_MISALIGN_EN when it is defined for the build.
module tb_dmem_hs;
`ifdef DMEM_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam int WAIT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        req_valid_z, req_ready_z, resp_valid_z, resp_ready_z, resp_err_z;
    logic [31:0] resp_rdata_z;

    logic [7:0]  model_mem [256];
    logic [31:0] last_rdata;
    logic        last_err;
    int          n_compared;
    int          n_mismatched;

    dmem_hs #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_hs #(.ADDR_W(8), .DATA_W(32), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
        .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference: an access is a run of 1/2/4 consecutive bytes, read as an unsigned number and sign-corrected.
    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [7:0] addr, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd, output int lat);
        int     nbytes;
        bit     mis;
        longint v;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis    = (size != 2'd3) && ((int'(addr) % nbytes) != 0);
        err    = (size == 2'd3) || (mis && !MIS_EN);
        lat    = WAIT + ((mis && MIS_EN) ? 1 : 0);
        rd     = 32'h0;
        v      = 0;
        if (!err) begin
            for (int k = 0; k < nbytes; k++) begin
                if (we) model_mem[(int'(addr) + k) % 256] = wd[8*k +: 8];
                else    v = v + (longint'(model_mem[(int'(addr) + k) % 256]) << (8 * k));
            end
            if (!we) begin
                if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v - (longint'(1) << (8 * nbytes));
                rd = v[31:0];
            end
        end
    endtask

    // One full transaction on the WAIT_CYC=2 instance; bp < 0 picks a random backpressure length.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [7:0] addr, input logic [31:0] wd, input int bp);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat, lat, n;
        model_access(we, size, uns, addr, wd, exp_err, exp_rd, exp_lat);
        checkOutput("ready_idle", req_ready, 1);
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            checkOutput("ready_busy", req_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, exp_lat);
        checkOutput("ready_resp", req_ready, 0);
        checkOutput("rdata", resp_rdata, exp_rd);
        checkOutput("err", resp_err, exp_err);
        last_rdata = resp_rdata;
        last_err   = resp_err;
        n = (bp < 0) ? $urandom_range(0, 3) : bp;
        repeat (n) begin
            req_valid = 1'($urandom_range(0, 1)); req_we = 1; req_size = 2'd2;
            req_addr = 8'($urandom); req_wdata = $urandom;
            @(posedge clk); #1;
            checkOutput("bp_valid", resp_valid, 1);
            checkOutput("bp_rdata", resp_rdata, exp_rd);
            checkOutput("bp_err", resp_err, exp_err);
            checkOutput("bp_ready", req_ready, 0);
        end
        req_valid  = 0;
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        checkOutput("valid_clear", resp_valid, 0);
        checkOutput("ready_back", req_ready, 1);
    endtask

    task automatic run_zero(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd);
        req_we = we; req_size = 2'd2; req_unsigned = 0; req_addr = addr; req_wdata = wd;
        req_valid_z = 1;
        @(posedge clk); #1;
        req_valid_z = 0;
        checkOutput("z_valid_at_e0", resp_valid_z, 1);
        checkOutput("z_ready_busy", req_ready_z, 0);
        checkOutput("z_rdata", resp_rdata_z, exp_rd);
        checkOutput("z_err", resp_err_z, 0);
        resp_ready_z = 1;
        @(posedge clk); #1;
        resp_ready_z = 0;
        checkOutput("z_valid_clear", resp_valid_z, 0);
        checkOutput("z_ready_back", req_ready_z, 1);
    endtask

    initial begin
        logic [1:0] sz;
        logic [7:0] ad;
        n_compared = 0; n_mismatched = 0;
        rst = 1; req_valid = 0; req_valid_z = 0; resp_ready = 0; resp_ready_z = 0;
        req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        #3;
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_valid", resp_valid, 0);
        checkOutput("rst_rdata", resp_rdata, 0);
        checkOutput("rst_err", resp_err, 0);
        @(posedge clk); #1;
        rst = 0;
        #1;
        checkOutput("ready_after_rst", req_ready, 1);
        checkOutput("z_ready_after_rst", req_ready_z, 1);

        for (int a = 0; a < 64; a++) applyStimulus(1, 2'd2, 0, 8'(a * 4), $urandom, -1);

        applyStimulus(1, 2'd2, 0, 8'h10, 32'h800000F1, -1);
        applyStimulus(0, 2'd0, 0, 8'h10, 0, -1); checkOutput("lb_10", last_rdata, 32'hFFFFFFF1);
        applyStimulus(0, 2'd0, 1, 8'h10, 0, -1); checkOutput("lbu_10", last_rdata, 32'h000000F1);
        applyStimulus(0, 2'd1, 0, 8'h12, 0, -1); checkOutput("lh_12", last_rdata, 32'hFFFF8000);
        applyStimulus(0, 2'd1, 1, 8'h12, 0, -1); checkOutput("lhu_12", last_rdata, 32'h00008000);
        applyStimulus(0, 2'd2, 0, 8'h10, 0, 4);  checkOutput("lw_10", last_rdata, 32'h800000F1);

        applyStimulus(0, 2'd3, 0, 8'h10, 0, -1); checkOutput("size11_err", last_err, 1);
`ifndef DMEM_MISALIGN_EN
        applyStimulus(0, 2'd2, 0, 8'h11, 0, -1); checkOutput("lw_11_err", last_err, 1);
        applyStimulus(0, 2'd1, 0, 8'h13, 0, -1); checkOutput("lh_13_err", last_err, 1);
        applyStimulus(1, 2'd2, 0, 8'h12, 32'hDEADBEEF, -1); checkOutput("sw_12_err", last_err, 1);
        applyStimulus(0, 2'd2, 0, 8'h10, 0, -1); checkOutput("lw_10_kept", last_rdata, 32'h800000F1);
`else
        applyStimulus(1, 2'd2, 0, 8'hFF, 32'h44332211, -1); checkOutput("sw_ff_err", last_err, 0);
        applyStimulus(0, 2'd0, 1, 8'hFF, 0, -1); checkOutput("wrap_ff", last_rdata, 32'h11);
        applyStimulus(0, 2'd0, 1, 8'h00, 0, -1); checkOutput("wrap_00", last_rdata, 32'h22);
        applyStimulus(0, 2'd0, 1, 8'h01, 0, -1); checkOutput("wrap_01", last_rdata, 32'h33);
        applyStimulus(0, 2'd0, 1, 8'h02, 0, -1); checkOutput("wrap_02", last_rdata, 32'h44);
`endif

        applyStimulus(1, 2'd2, 0, 8'h30, 32'hAABBCCDD, -1);
        applyStimulus(1, 2'd0, 0, 8'h31, 32'h00000011, -1);
        applyStimulus(1, 2'd1, 0, 8'h32, 32'h00002233, -1);
        applyStimulus(0, 2'd2, 0, 8'h30, 0, -1); checkOutput("merge_30", last_rdata, 32'h223311DD);

        // Store abandoned by reset while still waiting; model memory is left untouched.
        req_valid = 1; req_we = 1; req_size = 2'd2; req_unsigned = 0;
        req_addr = 8'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 0;
        #2 rst = 1;
        #1;
        checkOutput("midrst_valid", resp_valid, 0);
        checkOutput("midrst_ready", req_ready, 0);
        @(posedge clk); #1;
        checkOutput("midrst_ready_hold", req_ready, 0);
        rst = 0;
        #1;
        checkOutput("midrst_ready_release", req_ready, 1);
        applyStimulus(0, 2'd2, 0, 8'h20, 0, -1);

        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 8'($urandom);
            if ($urandom_range(0, 1) == 0) ad = (sz == 2'd2) ? (ad & 8'hFC) : (sz == 2'd1) ? (ad & 8'hFE) : ad;
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, -1);
        end

        run_zero(1, 8'h40, 32'hCAFEF00D, 32'h0);
        run_zero(0, 8'h40, 32'h0, 32'hCAFEF00D);
        run_zero(1, 8'h44, 32'h01234567, 32'h0);
        run_zero(0, 8'h44, 32'h0, 32'h01234567);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
